mips_state_dumper: RTL and testbench

Hardware run-and-dump controller for the single-cycle MIPS core. It counts CPU execution cycles after reset and stops on a cycle budget or an external halt. It then freezes the core and streams register-file and data-memory contents out over a valid/ready channel, one index per beat. It replaces the fixed-delay, fixed-32-entry dump loop in the bench with a parametrised, synthesizable block. It sits beside `MIPS`, driving the core's stall input and the spare read ports of the register file and data memory.

---
 rtl/mips_state_dumper_if.sv | 14 +
 rtl/mips_state_dumper.sv | 130 +++++++++++++
 tb/tb_mips_state_dumper.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_state_dumper_if.sv
// Dump stream channel: one beat per index carrying the register-file and data-memory words.
interface mips_state_dumper_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);
   logic              dump_valid;
   logic              dump_ready;
   logic [IDX_W-1:0]  dump_idx;
   logic [DATA_W-1:0] dump_rf;
   logic [DATA_W-1:0] dump_dm;

   modport master (output dump_valid, dump_idx, dump_rf, dump_dm, input dump_ready);
   modport slave  (input dump_valid, dump_idx, dump_rf, dump_dm, output dump_ready);
endinterface

// File: rtl/mips_state_dumper.sv
// Run-and-dump controller: lets the MIPS core run for a cycle budget or until halt,
// then freezes it and streams RF/DM contents out one index per beat.
module mips_state_dumper #(
   parameter int DATA_W     = 32,
   parameter int N_ENTRIES  = 32,
   parameter int IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
   parameter int RUN_CYCLES = 140,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   output logic              cpu_hold,
   output logic [IDX_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [IDX_W-1:0]  dm_raddr,
   input  logic [DATA_W-1:0] dm_rdata,
   mips_state_dumper_if.master dump,
   output logic [CNT_W-1:0]  cycles_run,
   output logic              done
);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DUMP  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [DATA_W-1:0] out_rf_q, out_rf_d;
   logic [DATA_W-1:0] out_dm_q, out_dm_d;
   logic              load_s;

   // Next-state, counter, read index and output-register update
   always_comb begin
      state_d   = state_q;
      cycles_d  = cycles_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      out_idx_d = out_idx_q;
      out_rf_d  = out_rf_q;
      out_dm_d  = out_dm_q;
      load_s    = 1'b0;
      case (state_q)
         ST_RUN: begin
            cycles_d = cycles_q + CNT_W'(1);
            if ((cycles_q == RUN_LAST) || halt) begin
               state_d = ST_DUMP;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DUMP: begin
            // The output register refills whenever it is empty or being consumed.
            load_s = !valid_q || dump.dump_ready;
            if (load_s) begin
               out_rf_d  = rf_rdata;
               out_dm_d  = dm_rdata;
               out_idx_d = idx_q;
               valid_d   = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = idx_q;
                  state_d = ST_DRAIN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_DUMP;
               end
            end else begin
               state_d = ST_DUMP;
            end
         end
         ST_DRAIN: begin
            if (valid_q && dump.dump_ready) begin
               valid_d = 1'b0;
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         cycles_q  <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         out_idx_q <= '0;
         out_rf_q  <= '0;
         out_dm_q  <= '0;
      end else begin
         state_q   <= state_d;
         cycles_q  <= cycles_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         out_idx_q <= out_idx_d;
         out_rf_q  <= out_rf_d;
         out_dm_q  <= out_dm_d;
      end
   end

   // Status decoded straight from the state register
   always_comb begin
      cpu_hold = (state_q != ST_RUN);
      done     = (state_q == ST_DONE);
   end

   assign rf_raddr        = idx_q;
   assign dm_raddr        = idx_q;
   assign cycles_run      = cycles_q;
   assign dump.dump_valid = valid_q;
   assign dump.dump_idx   = out_idx_q;
   assign dump.dump_rf    = out_rf_q;
   assign dump.dump_dm    = out_dm_q;
endmodule

// File: tb/tb_mips_state_dumper.sv
// Directed bench: a default dumper beside a mock core/memories, plus a 1-entry, 1-cycle instance.
module tb_mips_state_dumper;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        halt2 = 1'b0;
   logic        cpu_hold, done, cpu_hold2, done2;
   logic [4:0]  rf_raddr, dm_raddr;
   logic [31:0] rf_rdata, dm_rdata, cycles_run;
   logic [0:0]  rf2_raddr, dm2_raddr;
   logic [31:0] rf2_rdata, dm2_rdata, cycles2;
   logic [31:0] dm_mem [32];
   logic [15:0] pc;
   int          beats2;
   int          n_tests = 0;
   int          n_fail = 0;

   mips_state_dumper_if #(.DATA_W(32), .IDX_W(5)) bus1 ();
   mips_state_dumper_if #(.DATA_W(32), .IDX_W(1)) bus2 ();

   mips_state_dumper dut (
      .clk(clk), .rst(rst), .halt(halt), .cpu_hold(cpu_hold),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .dump(bus1.master), .cycles_run(cycles_run), .done(done)
   );

   mips_state_dumper #(.N_ENTRIES(1), .RUN_CYCLES(1)) dut2 (
      .clk(clk), .rst(rst), .halt(halt2), .cpu_hold(cpu_hold2),
      .rf_raddr(rf2_raddr), .rf_rdata(rf2_rdata), .dm_raddr(dm2_raddr), .dm_rdata(dm2_rdata),
      .dump(bus2.master), .cycles_run(cycles2), .done(done2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pre_rf(int i);
      return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   function automatic logic [31:0] pre_dm(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Memory word i after the core ran h unstalled edges writing dm[pc%32] = {D000, pc}.
   function automatic logic [31:0] exp_dm(int i, int h);
      int p = -1;
      for (int q = 0; q < h; q++) begin
         if ((q % 32) == i) p = q;
      end
      return (p < 0) ? pre_dm(i) : {16'hD000, 16'(p)};
   endfunction

   assign rf_rdata        = pre_rf(int'(rf_raddr));
   assign dm_rdata        = dm_mem[dm_raddr];
   assign rf2_rdata       = 32'h2222_0000 | 32'(rf2_raddr);
   assign dm2_rdata       = 32'h3333_0000 | 32'(dm2_raddr);
   assign bus2.dump_ready = 1'b1;

   // Mock core: preloads memory under reset, writes one word per edge unless held
   always @(posedge clk) begin
      if (rst) begin
         pc <= 16'd0;
         for (int i = 0; i < 32; i++) dm_mem[i] <= pre_dm(i);
      end else if (!cpu_hold) begin
         pc <= pc + 16'd1;
         dm_mem[pc[4:0]] <= {16'hD000, pc};
      end
   end

   // Counts accepted beats of the single-entry instance
   always @(posedge clk) begin
      if (rst) beats2 <= 0;
      else if (bus2.dump_valid && bus2.dump_ready) beats2 <= beats2 + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " hold"}, 64'(cpu_hold), 64'd0);
      chk({tag, " cycles"}, 64'(cycles_run), 64'd0);
      chk({tag, " valid"}, 64'(bus1.dump_valid), 64'd0);
      chk({tag, " idx"}, 64'(bus1.dump_idx), 64'd0);
      chk({tag, " rf"}, 64'(bus1.dump_rf), 64'd0);
      chk({tag, " dm"}, 64'(bus1.dump_dm), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " raddr"}, 64'(rf_raddr), 64'd0);
   endtask

   initial begin
      logic        cap_v;
      logic [4:0]  cap_idx;
      logic [31:0] cap_rf, cap_dm;
      int          next_idx;

      bus1.dump_ready = 1'b1;
      step(2);
      chk_reset_outputs("reset");

      // Auto stop at the budget, ready tied high
      rst = 1'b0;
      step(1);
      chk("n1 hold e1", 64'(cpu_hold2), 64'd1);
      chk("n1 cycles e1", 64'(cycles2), 64'd1);
      chk("n1 valid e1", 64'(bus2.dump_valid), 64'd0);
      chk("cycles e1", 64'(cycles_run), 64'd1);
      step(1);
      chk("n1 valid e2", 64'(bus2.dump_valid), 64'd1);
      chk("n1 idx e2", 64'(bus2.dump_idx), 64'd0);
      chk("n1 rf e2", 64'(bus2.dump_rf), 64'h2222_0000);
      chk("n1 dm e2", 64'(bus2.dump_dm), 64'h3333_0000);
      chk("n1 done e2", 64'(done2), 64'd0);
      step(1);
      chk("n1 done e3", 64'(done2), 64'd1);
      chk("n1 valid e3", 64'(bus2.dump_valid), 64'd0);
      step(1);
      chk("n1 beats", 64'(beats2), 64'd1);
      chk("n1 cycles frozen", 64'(cycles2), 64'd1);
      step(135);
      chk("cycles e139", 64'(cycles_run), 64'd139);
      chk("hold e139", 64'(cpu_hold), 64'd0);
      step(1);
      chk("hold e140", 64'(cpu_hold), 64'd1);
      chk("cycles e140", 64'(cycles_run), 64'd140);
      chk("valid e140", 64'(bus1.dump_valid), 64'd0);
      for (int i = 0; i < 32; i++) begin
         step(1);
         chk("auto valid", 64'(bus1.dump_valid), 64'd1);
         chk("auto idx", 64'(bus1.dump_idx), 64'(i));
         chk("auto rf", 64'(bus1.dump_rf), 64'(pre_rf(i)));
         chk("auto dm", 64'(bus1.dump_dm), 64'(exp_dm(i, 140)));
         chk("auto done", 64'(done), 64'd0);
      end
      step(1);
      chk("auto done e173", 64'(done), 64'd1);
      chk("auto valid e173", 64'(bus1.dump_valid), 64'd0);
      step(3);
      chk("auto cycles frozen", 64'(cycles_run), 64'd140);
      chk("auto hold in done", 64'(cpu_hold), 64'd1);
      chk("auto idx held", 64'(bus1.dump_idx), 64'd31);

      // Halt pulsed at edge 50; halt during the dump must be ignored
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(49);
      halt = 1'b1;
      step(1);
      halt = 1'b0;
      chk("halt cycles", 64'(cycles_run), 64'd50);
      chk("halt hold", 64'(cpu_hold), 64'd1);
      halt = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step(1);
         chk("halt idx", 64'(bus1.dump_idx), 64'(i));
         chk("halt rf", 64'(bus1.dump_rf), 64'(pre_rf(i)));
         chk("halt dm", 64'(bus1.dump_dm), 64'(exp_dm(i, 50)));
      end
      halt = 1'b0;
      step(1);
      chk("halt done", 64'(done), 64'd1);
      chk("halt cycles frozen", 64'(cycles_run), 64'd50);

      // Ready pattern 1-0-0-1 after a halt at edge 20
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(19);
      halt = 1'b1;
      step(1);
      halt = 1'b0;
      next_idx = 0;
      for (int c = 0; c < 400 && done !== 1'b1; c++) begin
         cap_v   = bus1.dump_valid;
         cap_idx = bus1.dump_idx;
         cap_rf  = bus1.dump_rf;
         cap_dm  = bus1.dump_dm;
         bus1.dump_ready = ((c % 4) == 0) || ((c % 4) == 3);
         step(1);
         if (cap_v && bus1.dump_ready) begin
            chk("tog idx", 64'(cap_idx), 64'(next_idx));
            chk("tog rf", 64'(cap_rf), 64'(pre_rf(next_idx)));
            chk("tog dm", 64'(cap_dm), 64'(exp_dm(next_idx, 20)));
            next_idx++;
         end else if (cap_v) begin
            chk("tog stall valid", 64'(bus1.dump_valid), 64'd1);
            chk("tog stall idx", 64'(bus1.dump_idx), 64'(cap_idx));
            chk("tog stall rf", 64'(bus1.dump_rf), 64'(cap_rf));
            chk("tog stall dm", 64'(bus1.dump_dm), 64'(cap_dm));
         end
      end
      chk("tog beats", 64'(next_idx), 64'd32);
      chk("tog done", 64'(done), 64'd1);

      // Same-edge halt+budget on the small instance; reset mid-dump on the main one
      bus1.dump_ready = 1'b1;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      halt2 = 1'b1;
      step(1);
      halt2 = 1'b0;
      chk("n1 both cycles", 64'(cycles2), 64'd1);
      chk("n1 both hold", 64'(cpu_hold2), 64'd1);
      step(1);
      halt = 1'b1;
      step(1);
      halt = 1'b0;
      chk("n1 both done", 64'(done2), 64'd1);
      chk("mid cycles", 64'(cycles_run), 64'd3);
      step(1);
      chk("n1 both beats", 64'(beats2), 64'd1);
      chk("n1 both valid", 64'(bus2.dump_valid), 64'd0);
      for (int c = 0; c < 40 && !(bus1.dump_valid === 1'b1 && bus1.dump_idx === 5'd10); c++) begin
         step(1);
      end
      chk("mid at idx10", 64'(bus1.dump_idx), 64'd10);
      chk("mid dm idx10", 64'(bus1.dump_dm), 64'(exp_dm(10, 3)));
      rst = 1'b1;
      step(1);
      chk_reset_outputs("mid reset");
      rst = 1'b0;
      step(1);
      chk("restart cycles e1", 64'(cycles_run), 64'd1);
      step(2);
      chk("restart cycles e3", 64'(cycles_run), 64'd3);
      chk("restart hold", 64'(cpu_hold), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
